// File: rtl/led_activity_host_if.sv
// led_activity_host_if: LED_IF carries the LED State bit from an activity host to the LED device.
interface LED_IF;
    logic State;
    modport HOST(output State);
    modport DEVICE(input State);
endinterface

// File: rtl/led_activity_host.sv
// led_activity_host: turns ACCESS edges / BUSY levels into a min-ON, max-ON-with-gap LED State stream.
// Optional LED_ACTIVITY_SYNC_EN adds a two-flop input synchronizer for asynchronous sources.
module led_activity_host #(
    parameter int MIN_ON  = 2_148_000,
    parameter int MAX_ON  = 10_740_000,
    parameter int GAP_LEN = 1_074_000
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic ACCESS,
    input  logic BUSY,
    LED_IF.HOST  Led
);
    localparam int HW = $clog2(MIN_ON + 1);
    localparam int RW = $clog2(MAX_ON + 1);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam logic LED_STATE_OFF = 1'b0;
    localparam logic LED_STATE_ON  = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] run_q, run_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pending_q, pending_d;
    logic          access_q;
    logic          acc_s, busy_s, act;

`ifdef LED_ACTIVITY_SYNC_EN
    logic [1:0] acc_sync_q, busy_sync_q;
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            acc_sync_q  <= '0;
            busy_sync_q <= '0;
        end else begin
            acc_sync_q  <= {acc_sync_q[0], ACCESS};
            busy_sync_q <= {busy_sync_q[0], BUSY};
        end
    end
    assign acc_s  = acc_sync_q[1];
    assign busy_s = busy_sync_q[1];
`else
    assign acc_s  = ACCESS;
    assign busy_s = BUSY;
`endif

    // A held ACCESS is one event; BUSY counts every cycle it is high.
    assign act = (acc_s & ~access_q) | busy_s;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        run_d     = run_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (act) begin
                    state_d = S_ON;
                    hold_d  = HW'(MIN_ON - 1);
                    run_d   = '0;
                end
            end
            S_ON: begin
                if (run_q == RW'(MAX_ON - 1)) begin
                    state_d   = S_GAP;
                    gap_d     = GW'(GAP_LEN - 1);
                    pending_d = act;
                end else if (act) begin
                    hold_d = HW'(MIN_ON - 1);
                    run_d  = run_q + RW'(1);
                end else if (hold_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                    run_d  = run_q + RW'(1);
                end
            end
            S_GAP: begin
                if (act)
                    pending_d = 1'b1;
                if (gap_q == '0) begin
                    state_d   = (pending_q | act) ? S_ON : S_IDLE;
                    hold_d    = HW'(MIN_ON - 1);
                    run_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            run_q     <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            access_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            run_q     <= run_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            access_q  <= acc_s;
        end
    end

    assign Led.State = (state_q == S_ON) ? LED_STATE_ON : LED_STATE_OFF;
endmodule

// File: tb/tb_led_activity_host.sv
// tb_led_activity_host: directed + random stimulus against a timestamp-based reference of the LED rules.
module tb_led_activity_host;
    localparam int MIN_ON  = 4;
    localparam int MAX_ON  = 10;
    localparam int GAP_LEN = 3;
`ifdef LED_ACTIVITY_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int M_OFF = 0, M_ON = 1, M_GAP = 2;

    logic CLK = 1'b0, RESET_n = 1'b0, ACCESS = 1'b0, BUSY = 1'b0;
    LED_IF led();

    led_activity_host #(.MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .GAP_LEN(GAP_LEN)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .ACCESS(ACCESS), .BUSY(BUSY), .Led(led)
    );

    always #5 CLK = ~CLK;

    int vectors = 0, errors = 0;

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: State=%0b expected %0b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: absolute cycle timestamps for burst start, last event and gap end.
    int t, mode, on_start, last_ev, gap_end;
    bit pending, prev_acc;
    bit pa[2], pb[2];

    task automatic model_reset();
        t = 0; mode = M_OFF; on_start = 0; last_ev = 0; gap_end = 0;
        pending = 0; prev_acc = 0; pa = '{0, 0}; pb = '{0, 0};
    endtask

    task automatic model_step(input bit a_pin, input bit b_pin);
        bit ea, eb, act;
`ifdef LED_ACTIVITY_SYNC_EN
        ea = pa[1]; pa[1] = pa[0]; pa[0] = a_pin;
        eb = pb[1]; pb[1] = pb[0]; pb[0] = b_pin;
`else
        ea = a_pin; eb = b_pin;
`endif
        act = (ea & ~prev_acc) | eb;
        prev_acc = ea;
        if (mode == M_OFF) begin
            if (act) begin mode = M_ON; on_start = t + 1; last_ev = t; end
        end else if (mode == M_ON) begin
            if (t - on_start == MAX_ON - 1) begin
                mode = M_GAP; gap_end = t + GAP_LEN; pending = act;
            end else if (act) last_ev = t;
            else if (t - last_ev == MIN_ON) mode = M_OFF;
        end else begin
            pending |= act;
            if (t == gap_end) begin
                if (pending) begin mode = M_ON; on_start = t + 1; last_ev = t; end
                else mode = M_OFF;
                pending = 0;
            end
        end
        t++;
    endtask

    task automatic cycle(input bit a, input bit b, input string tag);
        ACCESS = a; BUSY = b;
        model_step(a, b);
        @(posedge CLK); #1;
        check(tag, led.State, mode == M_ON);
    endtask

    function automatic bit busy_on(input int n);
        int d = n - (LAT - 1);
        return (d >= 1 && d <= 10) || (d >= 14 && d <= 23) || (d >= 27 && d <= 33);
    endfunction

    initial begin
        int pa_pct, pb_pct;
        model_reset();
        #1 check("reset", led.State, 1'b0);
        @(posedge CLK); @(posedge CLK); #1 RESET_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(0, 0, "idle");
        cycle(1, 0, "pulse");
        for (int i = 1; i < 10; i++) begin
            cycle(0, 0, "pulse");
            check("pulse_tl", led.State, (i + 1 - (LAT - 1)) >= 1 && (i + 1 - (LAT - 1)) <= 4);
        end
        for (int i = 0; i < 50; i++) cycle(1, 0, "held");
        for (int i = 0; i < 8; i++) cycle(0, 0, "held_rel");
        for (int c = 0; c < 40; c++) begin
            cycle(0, c < 30, "busy");
            check("busy_tl", led.State, busy_on(c + 1));
        end
        cycle(1, 0, "dbl"); cycle(0, 0, "dbl"); cycle(0, 0, "dbl"); cycle(1, 0, "dbl");
        for (int i = 0; i < 10; i++) cycle(0, 0, "dbl");
        cycle(1, 0, "rst_win"); cycle(0, 0, "rst_win"); cycle(0, 0, "rst_win");
        check("rst_win_on", led.State, 1'b1);
        #2 RESET_n = 1'b0;
        #1 check("rst_async", led.State, 1'b0);
        model_reset();
        @(posedge CLK); #1 RESET_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(0, 0, "rst_idle");
        for (int s = 0; s < 80; s++) begin
            pa_pct = $urandom_range(0, 60);
            pb_pct = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 100) : $urandom_range(0, 15);
            for (int i = 0; i < 40; i++)
                cycle($urandom_range(0, 99) < pa_pct, $urandom_range(0, 99) < pb_pct, "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
